// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 8-bit bus engines (reader and write sequencer).
// State encoding, busy-flag/address-counter bit positions and RS select values.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HIGH = 3'd2,
    ST_E_LOW  = 3'd3,
    ST_DONE   = 3'd4
  } lcd_rd_state_e;

  localparam int unsigned LCD_BF_BIT = 7;
  localparam int unsigned LCD_AC_MSB = 6;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase down-counter: load strobe sets the count, terminal count is flagged at zero.
// Loading with N-1 makes the current phase last exactly N cycles.
module lcd_phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side engine for the HD44780 8-bit bus: BF/AC and data reads with optional
// busy-flag polling. Pin outputs are registered from the next state so they track the FSM.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS      = 50,
  parameter int unsigned T_EH      = 25,
  parameter int unsigned T_EL      = 50,
  parameter int unsigned MAX_POLLS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_timeout,
  output logic       lcd_bus_busy,
  input  logic [7:0] data_in,
  output logic       data_out_en,
  output logic       data_out_rs,
  output logic       data_out_rw
);

  localparam int unsigned TMax = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                               : ((T_EH > T_EL) ? T_EH : T_EL);
  localparam int unsigned PhW = $clog2(TMax + 1);
  localparam int unsigned PcW = $clog2(MAX_POLLS + 1);

  localparam logic [PhW-1:0] LdAs = PhW'(T_AS - 1);
  localparam logic [PhW-1:0] LdEh = PhW'(T_EH - 1);
  localparam logic [PhW-1:0] LdEl = PhW'(T_EL - 1);
  localparam logic [PcW-1:0] MaxPolls = PcW'(MAX_POLLS);

  lcd_rd_state_e    state_q, state_d;
  logic             rs_lat_q, rs_lat_d;
  logic             poll_q, poll_d;
  logic [PcW-1:0]   poll_cnt_q, poll_cnt_d, poll_cnt_inc;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;

  logic             tmr_load;
  logic [PhW-1:0]   tmr_val;
  logic             tmr_tc;

  lcd_phase_timer #(
    .WIDTH (PhW)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    rs_lat_d   = rs_lat_q;
    poll_d     = poll_q;
    poll_cnt_d = poll_cnt_q;
    rd_data_d  = rd_data_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    // Saturating so a huge MAX_POLLS never wraps the counter.
    poll_cnt_inc = (poll_cnt_q < MaxPolls) ? poll_cnt_q + PcW'(1) : poll_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          rs_lat_d   = rd_rs;
          poll_d     = rd_poll & (rd_rs == RS_CMD);
          poll_cnt_d = '0;
          state_d    = ST_SETUP;
          tmr_load   = 1'b1;
          tmr_val    = LdAs;
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_E_HIGH;
          tmr_load = 1'b1;
          tmr_val  = LdEh;
        end
      end
      ST_E_HIGH: begin
        if (tmr_tc) begin
          rd_data_d = data_in;
          state_d   = ST_E_LOW;
          tmr_load  = 1'b1;
          tmr_val   = LdEl;
        end
      end
      ST_E_LOW: begin
        if (tmr_tc) begin
          poll_cnt_d = poll_cnt_inc;
          tmr_load   = 1'b1;
          if (poll_q && rd_data_q[LCD_BF_BIT] && (poll_cnt_inc < MaxPolls)) begin
            state_d = ST_SETUP;
            tmr_val = LdAs;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        tmr_load = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d == ST_SETUP) || (state_d == ST_E_HIGH) || (state_d == ST_E_LOW);
    rw_d      = busy_d;
    rs_d      = busy_d & rs_lat_d;
    en_d      = (state_d == ST_E_HIGH);
    valid_d   = (state_d == ST_DONE);
    timeout_d = valid_d & poll_q & rd_data_q[LCD_BF_BIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rs_lat_q   <= 1'b0;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
      rd_data_q  <= 8'h00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_lat_q   <= rs_lat_d;
      poll_q     <= poll_d;
      poll_cnt_q <= poll_cnt_d;
      rd_data_q  <= rd_data_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
    end
  end

  assign rd_ready     = (state_q == ST_IDLE);
  assign rd_valid     = valid_q;
  assign rd_data      = rd_data_q;
  assign rd_timeout   = timeout_q;
  assign lcd_bus_busy = busy_q;
  assign data_out_en  = en_q;
  assign data_out_rs  = rs_q;
  assign data_out_rw  = rw_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Bench for lcd_bus_reader: an LCD model answers each E pulse from a response list;
// table vectors, randomized reads against a spec-level model, and reset corner cases.
module tb_lcd_bus_reader;

  localparam int T_AS      = 2;
  localparam int T_EH      = 4;
  localparam int T_EL      = 3;
  localparam int MAX_POLLS = 4;
  localparam int PER       = T_AS + T_EH + T_EL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic       rd_rs = 1'b0;
  logic       rd_poll = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_ready, rd_valid, rd_timeout, lcd_bus_busy;
  logic [7:0] rd_data;
  logic       data_out_en, data_out_rs, data_out_rw;

  always #5 clk = ~clk;

  lcd_bus_reader #(
    .T_AS      (T_AS),
    .T_EH      (T_EH),
    .T_EL      (T_EL),
    .MAX_POLLS (MAX_POLLS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_rs        (rd_rs),
    .rd_poll      (rd_poll),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_timeout   (rd_timeout),
    .lcd_bus_busy (lcd_bus_busy),
    .data_in      (data_in),
    .data_out_en  (data_out_en),
    .data_out_rs  (data_out_rs),
    .data_out_rw  (data_out_rw)
  );

  int n_tot = 0;
  int n_pass = 0;
  int n_txn = 0;

  // Byte the LCD returns on the n-th E pulse of the current transaction.
  logic [7:0] resp [8];
  logic       exp_rs = 1'b0;

  int   pulses = 0;
  int   ehi_run = 0;
  int   ehi_bad = 0;
  int   rw_bad = 0;
  int   valid_cnt = 0;
  int   pidx = 0;
  logic en_prev = 1'b0;

  // LCD model and pin monitor; non-final E-high cycles carry a decoy byte.
  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
      ehi_run = 0;
      data_in = 8'h00;
    end else begin
      if (lcd_bus_busy && (!data_out_rw || data_out_rs !== exp_rs)) rw_bad++;
      if (!lcd_bus_busy && (data_out_rw || data_out_en)) rw_bad++;
      pidx = (pulses < 7) ? pulses : 7;
      if (data_out_en) begin
        ehi_run++;
        if (ehi_run > T_EH) ehi_bad++;
        if (ehi_run == T_EH) data_in = resp[pidx];
        else data_in = (resp[pidx] == 8'hAA) ? 8'h55 : 8'hAA;
      end else begin
        if (en_prev) begin
          if (ehi_run != T_EH) ehi_bad++;
          pulses++;
        end
        ehi_run = 0;
        data_in = 8'($urandom);
      end
      if (rd_valid) valid_cnt++;
      if (rd_ready) begin
        pulses  = 0;
        ehi_bad = 0;
        rw_bad  = 0;
      end
      en_prev = data_out_en;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic do_read(input string name, input logic rs, input logic poll,
                         input logic [7:0] exp_data, input logic exp_to,
                         input int exp_pulses, input bit poke);
    int n;
    int w;
    int ready_bad;
    w = 0;
    while (!rd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    exp_rs  = rs;
    rd_rs   = rs;
    rd_poll = poll;
    rd_req  = 1'b1;
    @(negedge clk);
    // Request inputs scrambled after acceptance must not matter.
    rd_req    = 1'b0;
    rd_rs     = 1'($urandom);
    rd_poll   = 1'($urandom);
    n         = 1;
    ready_bad = 0;
    while (!rd_valid && n < 200) begin
      if (rd_ready) ready_bad++;
      rd_req = poke && (n == 3);
      @(negedge clk);
      n++;
    end
    rd_req = 1'b0;
    n_txn++;
    chk({name, " latency"}, n, exp_pulses * PER + 1);
    chk({name, " rd_data"}, rd_data, exp_data);
    chk({name, " rd_timeout"}, rd_timeout, exp_to);
    chk({name, " e_pulses"}, pulses, exp_pulses);
    chk({name, " e_width_errs"}, ehi_bad, 0);
    chk({name, " rs_rw_errs"}, rw_bad, 0);
    chk({name, " ready_while_busy"}, ready_bad, 0);
    @(negedge clk);
    chk({name, " ready_after_done"}, rd_ready, 1'b1);
    chk({name, " valid_one_cycle"}, rd_valid, 1'b0);
  endtask

  typedef struct {
    string      name;
    logic       rs;
    logic       poll;
    logic [7:0] r [5];
    logic [7:0] exp_data;
    logic       exp_to;
    int         exp_pulses;
    bit         poke;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic       rs_r, poll_r, eff;
    logic [7:0] ed;
    int         k;

    vecs[0] = '{"data_rd",   1'b1, 1'b0, '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h52, 1'b0, 1, 1'b0};
    vecs[1] = '{"poll_ok",   1'b0, 1'b1, '{8'h85, 8'h85, 8'h05, 8'h00, 8'h00}, 8'h05, 1'b0, 3, 1'b0};
    vecs[2] = '{"poll_to",   1'b0, 1'b1, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, 8'h80, 1'b1, 4, 1'b0};
    vecs[3] = '{"sample_pt", 1'b1, 1'b0, '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h3C, 1'b0, 1, 1'b0};
    vecs[4] = '{"bf_nopoll", 1'b0, 1'b0, '{8'h9A, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h9A, 1'b0, 1, 1'b0};
    vecs[5] = '{"rs1_poll",  1'b1, 1'b1, '{8'hC1, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hC1, 1'b0, 1, 1'b0};
    vecs[6] = '{"ignored",   1'b1, 1'b0, '{8'h6E, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h6E, 1'b0, 1, 1'b1};
    vecs[7] = '{"poll_idle", 1'b0, 1'b1, '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h7F, 1'b0, 1, 1'b0};
    vecs[8] = '{"poll_to_ac", 1'b0, 1'b1, '{8'h81, 8'h82, 8'h83, 8'h84, 8'h05}, 8'h84, 1'b1, 4,
                1'b0};

    for (int j = 0; j < 8; j++) resp[j] = 8'h00;

    repeat (2) @(negedge clk);
    chk("reset rd_ready", rd_ready, 1'b1);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset rd_timeout", rd_timeout, 1'b0);
    chk("reset bus_busy", lcd_bus_busy, 1'b0);
    chk("reset e_rs_rw", {data_out_en, data_out_rs, data_out_rw}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8; j++) resp[j] = vecs[i].r[(j < 5) ? j : 4];
      do_read(vecs[i].name, vecs[i].rs, vecs[i].poll, vecs[i].exp_data, vecs[i].exp_to,
              vecs[i].exp_pulses, vecs[i].poke);
    end

    // Random reads: a poll reads until BF clears or MAX_POLLS reads have been made.
    for (int i = 0; i < 24; i++) begin
      rs_r   = 1'($urandom);
      poll_r = ($urandom_range(3) != 0);
      for (int j = 0; j < 8; j++) resp[j] = {($urandom_range(9) < 7), 7'($urandom)};
      eff = poll_r && (rs_r == 1'b0);
      k = 1;
      if (eff) while (k < MAX_POLLS && resp[k-1][7]) k++;
      ed = resp[k-1];
      do_read($sformatf("rand%0d", i), rs_r, poll_r, ed, eff && ed[7], k, 1'b0);
    end

    resp[0] = 8'h52;
    for (int j = 1; j < 8; j++) resp[j] = 8'h00;
    do_read("pre_reset", 1'b1, 1'b0, 8'h52, 1'b0, 1, 1'b0);

    // Reset during E_HIGH: outputs drop without a clock edge and the read is dropped.
    exp_rs  = 1'b1;
    rd_rs   = 1'b1;
    rd_poll = 1'b0;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst e_before", data_out_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst e", data_out_en, 1'b0);
    chk("midrst rw", data_out_rw, 1'b0);
    chk("midrst busy", lcd_bus_busy, 1'b0);
    chk("midrst rd_data", rd_data, 8'h00);
    chk("midrst rd_valid", rd_valid, 1'b0);
    chk("midrst rd_ready", rd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("valid_count", valid_cnt, n_txn);
    chk("post_rst rd_data", rd_data, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side engine for the 8-bit HD44780 character-LCD bus, the counterpart of the existing LCD write sequencer. It runs RW=1 bus cycles: busy-flag/address-counter reads (RS=0) and DDRAM/CGRAM data reads (RS=1). It can optionally poll the busy flag until the controller is idle, so the writer can replace fixed ~30 ms delays with real readiness. It sits between the write sequencer and the top-level tristate on the LCD data pins.

## Interface
- T_AS, 50: cycles RS/RW are stable before E rises (≥1)
- T_EH, 25: cycles E is held high (≥1)
- T_EL, 50: cycles E is low after the fall, RW still 1, before the bus is released (≥1)
- MAX_POLLS, 1000: busy-flag reads per poll request before timeout (≥1)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_req  in  1  start request; sampled only while rd_ready=1
- rd_rs  in  1  register select for the request (0 = BF/AC, 1 = data)
- rd_poll  in  1  with rd_rs=0, repeat BF reads until BF=0 or timeout
- rd_ready  out  1  high in IDLE only
- rd_valid  out  1  one-cycle completion pulse
- rd_data  out  8  last sampled byte, held until next capture
- rd_timeout  out  1  qualified by rd_valid; poll ended with BF still 1
- lcd_bus_busy  out  1  high from accept through end of E_LOW; writer must tristate and hold its E low
- data_in  in  8  LCD data pins, input path
- data_out_en  out  1  LCD E
- data_out_rs  out  1  LCD RS
- data_out_rw  out  1  LCD RW

## Operation
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE.
- IDLE: rd_ready=1, E=0, RW=0, bus_busy=0. If rd_req=1, latch rd_rs and rd_poll (rd_poll is forced to 0 when rd_rs=1), clear poll_cnt, and go to SETUP.
- SETUP: T_AS cycles. RS=latched value, RW=1, E=0, bus_busy=1.
- E_HIGH: T_EH cycles with E=1. rd_data <= data_in on the final E_HIGH cycle only.
- E_LOW: T_EL cycles with E=0, RW=1. On exit, poll_cnt is incremented.
  - Exit goes to SETUP if poll is latched, rd_data[7]=1 and poll_cnt<MAX_POLLS (after increment).
  - Otherwise exit goes to DONE.
- DONE: one cycle. rd_valid=1, rd_timeout=(poll latched & rd_data[7]), RW=0, bus_busy=0. Next state is IDLE.
- rd_data[7] is BF and rd_data[6:0] is AC when RS=0.
- No request queue. rd_req outside IDLE is ignored. rd_req in DONE is ignored, and is accepted in the following IDLE cycle.
- rd_rs and rd_poll changes after acceptance have no effect.
- Reset mid-operation: all outputs go to reset values immediately; no rd_valid is produced and the partial read is discarded.

## Timing
- Reset values:
  - state IDLE, rd_ready=1, rd_valid=0, rd_data=8'h00, rd_timeout=0, lcd_bus_busy=0.
  - data_out_en=0, data_out_rs=0, data_out_rw=0, poll_cnt=0.
- All outputs are registered except rd_ready, which is decoded from state.
- Single read latency, from the clk edge that accepts rd_req to rd_valid high: L = T_AS+T_EH+T_EL+1 cycles.
- A poll finishing after k reads has latency k·(T_AS+T_EH+T_EL)+1.
- Back-to-back requests: the minimum spacing between accepts is L+1 cycles.
- RS/RW change only while E=0. E never rises in the first SETUP cycle.
- The phase counter is $clog2(max(T_AS,T_EH,T_EL)+1) bits. poll_cnt is $clog2(MAX_POLLS+1) bits and saturates; it never wraps.

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - LCD_BF_BIT=7 and LCD_AC_MSB=6;
  - RS_CMD=0 and RS_DATA=1.
  The write sequencer reuses the RS constants.
- One sub-module, lcd_phase_timer: a down-counter with load value, load strobe and terminal-count output. The FSM reloads it on every state entry.
- The top-level tristate buffer stays outside this block. It drives the pins when lcd_bus_busy=0 and the writer enables them.

## Test plan
(Benches use T_AS=2, T_EH=4, T_EL=3, MAX_POLLS=4.)
- Single data read:
  - Stimulus: rd_req with rd_rs=1; data_in=8'h52 during E_HIGH.
  - Required: rd_valid exactly 10 cycles after accept; rd_data=8'h52; rd_timeout=0.
  - Required: E high for exactly 4 cycles; RW=1 throughout SETUP..E_LOW.
- Poll success:
  - Stimulus: rd_poll=1, rd_rs=0; the model returns 8'h85, 8'h85, then 8'h05.
  - Required: 3 E pulses; rd_valid at cycle 28; rd_data=8'h05; rd_timeout=0.
- Poll timeout:
  - Stimulus: the model always returns 8'h80.
  - Required: exactly 4 E pulses; rd_valid with rd_data=8'h80 and rd_timeout=1.
- Sampling point:
  - Stimulus: data_in=8'hAA for the first 3 E_HIGH cycles, 8'h3C on the 4th.
  - Required: rd_data=8'h3C.
- Ignored request:
  - Stimulus: rd_req pulsed during E_HIGH.
  - Required: no second transaction; rd_ready=0 until the cycle after DONE.
- Reset mid-read:
  - Stimulus: rst asserted during E_HIGH.
  - Required: data_out_en=0, RW=0 and lcd_bus_busy=0 asynchronously; no rd_valid; rd_data=8'h00.
